interboard_receiver: RTL and testbench

INTERBOARD_RECEIVER -- requirements
Module: interboard_receiver

---
 rtl/interboard_receiver.sv | 186 ++++++++++++++++++
 tb/tb_interboard_receiver.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/interboard_receiver.sv
// Receiving side of the 4-phase interboard link: synchronizes Request/data,
// assembles four 6-bit words and presents the decoded message with a valid pulse.
module interboard_receiver #(
    parameter logic [3:0]  MSG_RESET      = 4'hF,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       listen,
    input  logic       req_in,
    input  logic [5:0] data_in,
    output logic       ack_out,
    output logic       ack_oe,
    output logic       interboard_en,
    output logic       interboard_rst,
    output logic [3:0] interboard_msg_type,
    output logic       interboard_move_dir,
    output logic [2:0] interboard_sel_len,
    output logic [2:0] interboard_block_y,
    output logic [4:0] interboard_block_x,
    output logic [5:0] interboard_card,
    output logic       rx_error
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_WAIT_REQ = 2'd1;
    localparam logic [1:0] ST_ACK      = 2'd2;
    localparam logic [1:0] ST_DONE     = 2'd3;

    localparam int          CW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic          req_meta_reg, req_s_reg;
    logic [5:0]    data_meta_reg, data_s_reg;
    logic [1:0]    state_reg, state_next;
    logic [1:0]    wcnt_reg, wcnt_next;
    logic          ack_reg, ack_next;
    logic [CW-1:0] tmo_cnt_reg, tmo_cnt_next;
    logic          capture, done_pulse, timeout, counting;
    logic [5:0]    word_reg [3];
    logic [3:0]    tail_reg;
    logic [21:0]   msg_vec;
    logic          en_reg, rst_pulse_reg, err_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            req_meta_reg  <= 1'b0;
            req_s_reg     <= 1'b0;
            data_meta_reg <= '0;
            data_s_reg    <= '0;
        end else begin
            req_meta_reg  <= req_in;
            req_s_reg     <= req_meta_reg;
            data_meta_reg <= data_in;
            data_s_reg    <= data_meta_reg;
        end
    end

    // DONE always completes its pulse; otherwise listen=0 wins, then timeout.
    always_comb begin
        state_next = state_reg;
        wcnt_next  = wcnt_reg;
        ack_next   = ack_reg;
        capture    = 1'b0;
        done_pulse = 1'b0;
        timeout    = 1'b0;
        counting   = (state_reg == ST_ACK) || ((state_reg == ST_WAIT_REQ) && (wcnt_reg != 2'd0));
        if (state_reg == ST_DONE) begin
            done_pulse = 1'b1;
            wcnt_next  = 2'd0;
            ack_next   = 1'b0;
            state_next = listen ? ST_WAIT_REQ : ST_IDLE;
        end else if (!listen) begin
            state_next = ST_IDLE;
            wcnt_next  = 2'd0;
            ack_next   = 1'b0;
        end else if (counting && (tmo_cnt_reg == TMO_LAST)) begin
            timeout    = 1'b1;
            state_next = ST_WAIT_REQ;
            wcnt_next  = 2'd0;
            ack_next   = 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    state_next = ST_WAIT_REQ;
                    wcnt_next  = 2'd0;
                    ack_next   = 1'b0;
                end
                ST_WAIT_REQ: begin
                    if (req_s_reg) begin
                        capture    = 1'b1;
                        ack_next   = 1'b1;
                        state_next = ST_ACK;
                    end
                end
                ST_ACK: begin
                    if (!req_s_reg) begin
                        ack_next = 1'b0;
                        if (wcnt_reg == 2'd3) begin
                            state_next = ST_DONE;
                        end else begin
                            wcnt_next  = wcnt_reg + 2'd1;
                            state_next = ST_WAIT_REQ;
                        end
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        tmo_cnt_next = '0;
        if (counting && !timeout && (state_next == state_reg))
            tmo_cnt_next = tmo_cnt_reg + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg   <= ST_IDLE;
            wcnt_reg    <= 2'd0;
            ack_reg     <= 1'b0;
            tmo_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            wcnt_reg    <= wcnt_next;
            ack_reg     <= ack_next;
            tmo_cnt_reg <= tmo_cnt_next;
        end
    end

    // Word slots; the last word contributes only its upper four bits (the low two are padding).
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi = gi + 1) begin : g_word
            always_ff @(posedge clk) begin
                if (!rst)
                    word_reg[gi] <= '0;
                else if (capture && (wcnt_reg == 2'(gi)))
                    word_reg[gi] <= data_s_reg;
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst)
            tail_reg <= '0;
        else if (capture && (wcnt_reg == 2'd3))
            tail_reg <= data_s_reg[5:2];
    end

    assign msg_vec = {word_reg[0], word_reg[1], word_reg[2], tail_reg};

    always_ff @(posedge clk) begin
        if (!rst) begin
            en_reg              <= 1'b0;
            rst_pulse_reg       <= 1'b0;
            err_reg             <= 1'b0;
            interboard_msg_type <= '0;
            interboard_move_dir <= 1'b0;
            interboard_sel_len  <= '0;
            interboard_block_y  <= '0;
            interboard_block_x  <= '0;
            interboard_card     <= '0;
        end else begin
            en_reg        <= done_pulse;
            rst_pulse_reg <= done_pulse && (msg_vec[21:18] == MSG_RESET);
            err_reg       <= timeout;
            if (done_pulse) begin
                interboard_msg_type <= msg_vec[21:18];
                interboard_move_dir <= msg_vec[17];
                interboard_sel_len  <= msg_vec[16:14];
                interboard_block_y  <= msg_vec[13:11];
                interboard_block_x  <= msg_vec[10:6];
                interboard_card     <= msg_vec[5:0];
            end
        end
    end

    assign ack_out        = ack_reg;
    assign ack_oe         = listen;
    assign interboard_en  = en_reg;
    assign interboard_rst = rst_pulse_reg;
    assign rx_error       = err_reg;

endmodule

// File: tb/tb_interboard_receiver.sv
// Directed bench for interboard_receiver: table of messages with hand-decoded
// fields, plus sequences for timeout, listen drop, mid-message reset and long Request.
module tb_interboard_receiver;

    logic       clk;
    logic       rst;
    logic       listen;
    logic       req_in;
    logic [5:0] data_in;
    logic       ack_out;
    logic       ack_oe;
    logic       interboard_en;
    logic       interboard_rst;
    logic [3:0] interboard_msg_type;
    logic       interboard_move_dir;
    logic [2:0] interboard_sel_len;
    logic [2:0] interboard_block_y;
    logic [4:0] interboard_block_x;
    logic [5:0] interboard_card;
    logic       rx_error;

    interboard_receiver #(
        .MSG_RESET      (4'hF),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .listen              (listen),
        .req_in              (req_in),
        .data_in             (data_in),
        .ack_out             (ack_out),
        .ack_oe              (ack_oe),
        .interboard_en       (interboard_en),
        .interboard_rst      (interboard_rst),
        .interboard_msg_type (interboard_msg_type),
        .interboard_move_dir (interboard_move_dir),
        .interboard_sel_len  (interboard_sel_len),
        .interboard_block_y  (interboard_block_y),
        .interboard_block_x  (interboard_block_x),
        .interboard_card     (interboard_card),
        .rx_error            (rx_error)
    );

    typedef struct {
        logic [23:0] words;
        logic [3:0]  msg_type;
        logic        move_dir;
        logic [2:0]  sel_len;
        logic [2:0]  block_y;
        logic [4:0]  block_x;
        logic [5:0]  card;
        logic        is_rst;
    } vec_t;

    vec_t vecs [5];
    int   tests = 0;
    int   failed = 0;
    int   en_count = 0;
    int   err_count = 0;
    int   exp_en = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (interboard_en === 1'b1) en_count++;
        if (rx_error === 1'b1) err_count++;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_max(input string name, input int act, input int max);
        tests++;
        if (act > max) begin
            failed++;
            $display("FAIL %s: got %0d cycles, required <= %0d", name, act, max);
        end
    endtask

    function automatic logic [21:0] dut_fields();
        return {interboard_msg_type, interboard_move_dir, interboard_sel_len,
                interboard_block_y, interboard_block_x, interboard_card};
    endfunction

    function automatic logic [21:0] exp_fields(input vec_t v);
        return {v.msg_type, v.move_dir, v.sel_len, v.block_y, v.block_x, v.card};
    endfunction

    // One full 4-phase handshake; hold>0 keeps Request high that many extra cycles.
    task automatic send_word(input logic [5:0] w, input int hold);
        int lat;
        bit dropped;
        data_in = w;
        tick();
        tick();
        req_in = 1'b1;
        lat = 0;
        while (ack_out !== 1'b1 && lat < 10) begin
            tick();
            lat++;
        end
        check_max("ack_rise_latency", lat, 3);
        dropped = 1'b0;
        for (int h = 0; h < hold; h++) begin
            tick();
            if (ack_out !== 1'b1) dropped = 1'b1;
        end
        if (hold > 0) check("ack_held_high", 32'(dropped), 0);
        req_in = 1'b0;
        lat = 0;
        while (ack_out !== 1'b0 && lat < 10) begin
            tick();
            lat++;
        end
        check_max("ack_fall_latency", lat, 3);
    endtask

    task automatic apply_msg(input vec_t v, input int hold);
        for (int i = 0; i < 4; i++) send_word(v.words[23 - 6*i -: 6], hold);
        tick();
        check("en_after_w3_ack", 32'(interboard_en), 1);
        check("rst_pulse", 32'(interboard_rst), 32'(v.is_rst));
        check("fields", 32'(dut_fields()), 32'(exp_fields(v)));
        exp_en++;
        tick();
        check("en_one_cycle", 32'(interboard_en), 0);
        check("en_total", en_count, exp_en);
        $display("[TB] msg %06h hold %0d -> type %0h dir %0d len %0d y %0d x %0d card %0d rst %0d",
                 v.words, hold, interboard_msg_type, interboard_move_dir, interboard_sel_len,
                 interboard_block_y, interboard_block_x, interboard_card, v.is_rst);
    endtask

    initial begin
        int n;
        vecs[0] = '{{6'h0E, 6'h2B, 6'h06, 6'h28}, 4'h3, 1'b1, 3'd2, 3'd5, 5'd17, 6'd42, 1'b0};
        vecs[1] = '{{6'h3C, 6'h00, 6'h00, 6'h00}, 4'hF, 1'b0, 3'd0, 3'd0, 5'd0,  6'd0,  1'b1};
        vecs[2] = '{{6'h15, 6'h15, 6'h15, 6'h14}, 4'h5, 1'b0, 3'd5, 3'd2, 5'd21, 6'd21, 1'b0};
        vecs[3] = '{{6'h2A, 6'h2A, 6'h2A, 6'h28}, 4'hA, 1'b1, 3'd2, 3'd5, 5'd10, 6'd42, 1'b0};
        vecs[4] = '{{6'h39, 6'h00, 6'h00, 6'h03}, 4'hE, 1'b0, 3'd4, 3'd0, 5'd0,  6'd0,  1'b0};

        rst = 1'b0;
        listen = 1'b0;
        req_in = 1'b0;
        data_in = 6'h00;
        tick(); tick(); tick();
        check("reset_outputs", 32'({ack_out, interboard_en, interboard_rst, rx_error, dut_fields()}), 0);
        check("ack_oe_low", 32'(ack_oe), 0);
        listen = 1'b1;
        tick();
        check("ack_oe_high", 32'(ack_oe), 1);
        rst = 1'b1;
        tick(); tick();
        $display("[TB] reset released");

        for (int k = 0; k < 5; k++) apply_msg(vecs[k], 0);

        // Sender stalls after W1: abort must fire 100 cycles after the W1 Ack drops.
        send_word(vecs[2].words[23:18], 0);
        send_word(vecs[2].words[17:12], 0);
        n = 0;
        while (rx_error !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check("timeout_cycles", n, 100);
        tick();
        check("rx_error_one_cycle", 32'(rx_error), 0);
        check("fields_after_timeout", 32'(dut_fields()), 32'(exp_fields(vecs[4])));
        check("no_en_on_timeout", en_count, exp_en);
        check("rx_error_total", err_count, 1);
        $display("[TB] timeout after %0d cycles", n);
        apply_msg(vecs[0], 0);

        // listen drops while the W2 Ack is up.
        send_word(vecs[3].words[23:18], 0);
        send_word(vecs[3].words[17:12], 0);
        data_in = vecs[3].words[11:6];
        tick(); tick();
        req_in = 1'b1;
        n = 0;
        while (ack_out !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        check_max("w2_ack_rise_latency", n, 3);
        listen = 1'b0;
        tick();
        check("ack_cleared_on_listen", 32'(ack_out), 0);
        check("ack_oe_follows_listen", 32'(ack_oe), 0);
        req_in = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("fields_after_listen_drop", 32'(dut_fields()), 32'(exp_fields(vecs[0])));
        check("no_en_on_listen_drop", en_count, exp_en);
        listen = 1'b1;
        tick(); tick(); tick();
        $display("[TB] listen dropped in W2 ack and restored");
        apply_msg(vecs[2], 0);

        // Reset after W2 discards the partial message.
        send_word(vecs[0].words[23:18], 0);
        send_word(vecs[0].words[17:12], 0);
        send_word(vecs[0].words[11:6], 0);
        rst = 1'b0;
        tick(); tick();
        check("outputs_in_reset", 32'({ack_out, interboard_en, interboard_rst, rx_error, dut_fields()}), 0);
        check("ack_oe_in_reset", 32'(ack_oe), 1);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("no_en_after_reset", en_count, exp_en);
        $display("[TB] reset mid-message");
        apply_msg(vecs[1], 0);

        // Request held 50 cycles per word.
        apply_msg(vecs[3], 50);

        for (int i = 0; i < 5; i++) tick();
        check("final_en_total", en_count, exp_en);
        check("final_rx_error_total", err_count, 1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
